// File: rtl/addsub_pkg.sv
// Shared constants and result type for the registered adder/subtractor.
package addsub_pkg;

    localparam int unsigned ADDSUB_DEFAULT_WIDTH = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic [ADDSUB_DEFAULT_WIDTH-1:0] z;
        logic                            C;
        logic                            V;
    } result_t;

endpackage

// File: rtl/adder_subtractor_full_adder.sv
// One-bit combinational full adder; one cell of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/adder_subtractor.sv
// Registered two's-complement adder/subtractor (M=0: A+B, M=1: A-B) with carry and overflow flags.
// Build option ADDSUB_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).
module adder_subtractor
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic [WIDTH-1:0] z,
    output logic             C,
    output logic             V
);

    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic             m_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

`ifdef ADDSUB_INPUT_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             m_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            m_q <= MODE_ADD;
        end else begin
            a_q <= A;
            b_q <= B;
            m_q <= M;
        end
    end

    always_comb begin
        a_op = a_q;
        b_op = b_q;
        m_op = m_q;
    end
`else
    always_comb begin
        a_op = A;
        b_op = B;
        m_op = M;
    end
`endif

    // Subtract is A + ~B + 1: invert B and feed the mode bit in as carry-in.
    always_comb begin
        b_eff    = b_op ^ {WIDTH{m_op}};
        carry[0] = m_op;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (a_op[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= '0;
            C <= 1'b0;
            V <= 1'b0;
        end else begin
            z <= sum;
            C <= carry[WIDTH];
            V <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_adder_subtractor.sv
// Self-checking bench for adder_subtractor (WIDTH=4); honours ADDSUB_INPUT_REG_EN for latency.
module tb_adder_subtractor;
    import addsub_pkg::*;

`ifdef ADDSUB_INPUT_REG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       M;
    logic [3:0] z;
    logic       C;
    logic       V;

    int unsigned n_checks;
    int unsigned n_pass;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        result_t    exp;
    } vec_t;

    vec_t    vecs [9];
    result_t sweep_exp [512];

    adder_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .M     (M),
        .z     (z),
        .C     (C),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_result(input string tag, input result_t got, input result_t exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got z=%h C=%b V=%b, expected z=%h C=%b V=%b",
                     tag, got.z, got.C, got.V, exp.z, exp.C, exp.V);
        end
    endtask

    function automatic result_t model(input logic [3:0] a, input logic [3:0] b, input logic m);
        result_t    r;
        logic [3:0] be;
        logic [4:0] full;
        be   = m ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {4'b0, m};
        r.z  = full[3:0];
        r.C  = full[4];
        r.V  = (a[3] == be[3]) && (full[3] != a[3]);
        return r;
    endfunction

    function automatic result_t mk(input logic [3:0] zz, input logic cc, input logic vv);
        result_t r;
        r.z = zz;
        r.C = cc;
        r.V = vv;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        vecs[0] = '{4'h1, 4'h1, MODE_ADD, mk(4'h2, 1'b0, 1'b0)};
        vecs[1] = '{4'h7, 4'h1, MODE_ADD, mk(4'h8, 1'b0, 1'b1)};
        vecs[2] = '{4'hF, 4'h1, MODE_ADD, mk(4'h0, 1'b1, 1'b0)};
        vecs[3] = '{4'h3, 4'h5, MODE_SUB, mk(4'hE, 1'b0, 1'b0)};
        vecs[4] = '{4'h8, 4'h1, MODE_SUB, mk(4'h7, 1'b1, 1'b1)};
        vecs[5] = '{4'h5, 4'h0, MODE_SUB, mk(4'h5, 1'b1, 1'b0)};
        vecs[6] = '{4'h6, 4'h6, MODE_SUB, mk(4'h0, 1'b1, 1'b0)};
        vecs[7] = '{4'h4, 4'h4, MODE_ADD, mk(4'h8, 1'b0, 1'b1)};
        vecs[8] = '{4'h9, 4'h9, MODE_ADD, mk(4'h2, 1'b1, 1'b1)};

        // Reset asserted from time 0, before any clock edge.
        rst_n = 1'b0;
        A = 4'h0;
        B = 4'h0;
        M = MODE_ADD;
        #2;
        check_result("reset", {z, C, V}, mk(4'h0, 1'b0, 1'b0));
        A = 4'h5;
        B = 4'h3;
        step();
        check_result("reset_hold", {z, C, V}, mk(4'h0, 1'b0, 1'b0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            A = vecs[i].a;
            B = vecs[i].b;
            M = vecs[i].m;
            repeat (LAT) step();
            check_result($sformatf("dir%0d", i), {z, C, V}, vecs[i].exp);
        end

        // Stream ops, then pull reset low between clock edges.
        for (int i = 0; i < 4; i++) begin
            A = 4'(i + 9);
            B = 4'(i + 2);
            M = i[0];
            step();
        end
        #3;
        rst_n = 1'b0;
        #1;
        check_result("async_clr", {z, C, V}, mk(4'h0, 1'b0, 1'b0));
        A = 4'hF;
        B = 4'hF;
        M = MODE_ADD;
        step();
        check_result("clr_hold", {z, C, V}, mk(4'h0, 1'b0, 1'b0));
        #2;
        rst_n = 1'b1;
        #1;
        check_result("post_release", {z, C, V}, mk(4'h0, 1'b0, 1'b0));
        A = 4'h2;
        B = 4'h3;
        M = MODE_ADD;
        for (int k = 1; k < int'(LAT); k++) begin
            step();
            check_result("fill_zero", {z, C, V}, mk(4'h0, 1'b0, 1'b0));
        end
        step();
        check_result("first_after_rst", {z, C, V}, mk(4'h5, 1'b0, 1'b0));

        // Exhaustive streaming sweep, one new op per clock.
        for (int i = 0; i < 512; i++) begin
            sweep_exp[i] = model(4'(i), 4'(i >> 4), i[8]);
        end
        for (int i = 0; i < 512 + int'(LAT) - 1; i++) begin
            if (i < 512) begin
                A = 4'(i);
                B = 4'(i >> 4);
                M = i[8];
            end
            step();
            if (i - int'(LAT) + 1 >= 0) begin
                check_result($sformatf("sweep%0d", i - int'(LAT) + 1), {z, C, V},
                             sweep_exp[i - int'(LAT) + 1]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
